// File: rtl/conv3x3_window_pe_if.sv
// Bundle for the 3x3 conv PE: serial weight port,
// pixel-column stream in, quantised results out.
interface conv3x3_window_pe_if #(
  parameter int DW    = 8,
  parameter int WW    = 8,
  parameter int ACC_W = 20,
  parameter int OUT_W = 8
);
  logic                    w_load;
  logic signed [WW-1:0]    w_data;
  logic                    w_ready;
  logic                    valid_in;
  logic                    row_start;
  logic signed [DW-1:0]    din_1;
  logic signed [DW-1:0]    din_2;
  logic signed [DW-1:0]    din_3;
  logic                    relu_en;
  logic [4:0]              shift;
  logic                    valid_out;
  logic signed [ACC_W-1:0] dout_acc;
  logic signed [OUT_W-1:0] dout_q;

  modport master (
    output w_load, w_data,
    output valid_in, row_start,
    output din_1, din_2, din_3,
    output relu_en, shift,
    input  w_ready, valid_out,
    input  dout_acc, dout_q
  );

  modport slave (
    input  w_load, w_data,
    input  valid_in, row_start,
    input  din_1, din_2, din_3,
    input  relu_en, shift,
    output w_ready, valid_out,
    output dout_acc, dout_q
  );
endinterface

// File: rtl/conv3x3_window_pe.sv
// 3x3 sliding-window conv PE: double-buffered weights,
// 4-stage MAC, ReLU, round-half-up shift, saturation.
module conv3x3_window_pe #(
  parameter int DW    = 8,
  parameter int WW    = 8,
  parameter int ACC_W = 20,
  parameter int OUT_W = 8
) (
  input logic                clk,
  input logic                rst_n,
  conv3x3_window_pe_if.slave pe
);
  localparam int PW = DW + WW;
  localparam int RW = PW + 2;
  localparam logic signed [ACC_W:0] QMAX =
    {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] QMIN =
    {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [WW-1:0]    w_sh_q  [9];
  logic signed [WW-1:0]    w_act_q [9];
  logic signed [WW-1:0]    w_use_q [9];
  logic [3:0]              idx_q;
  logic                    rdy_q;
  logic signed [DW-1:0]    px_q [3][3];
  logic [1:0]              fc_q, fc_d;
  logic                    launch;
  logic                    v0_q, v1_q, v2_q, v3_q;
  logic                    vo_q;
  logic signed [PW-1:0]    prod_q [9];
  logic signed [RW-1:0]    row_q [3];
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_o_q;
  logic signed [OUT_W-1:0] q_o_q, q_d;
  logic signed [ACC_W:0]   r_x, rnd_x, sh_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) begin
        w_sh_q[i]  <= '0;
        w_act_q[i] <= '0;
      end
      idx_q <= '0;
      rdy_q <= 1'b0;
    end else if (pe.w_load) begin
      w_sh_q[idx_q] <= pe.w_data;
      if (idx_q == 4'd8) begin
        for (int i = 0; i < 8; i++)
          w_act_q[i] <= w_sh_q[i];
        w_act_q[8] <= pe.w_data;
        idx_q      <= '0;
        rdy_q      <= 1'b1;
      end else begin
        idx_q <= idx_q + 4'd1;
      end
    end
  end

  always_comb begin
    fc_d = fc_q;
    if (pe.valid_in) begin
      if (pe.row_start)
        fc_d = 2'd1;
      else if (fc_q != 2'd3)
        fc_d = fc_q + 2'd1;
    end
  end

  assign launch = pe.valid_in && (fc_d == 2'd3);

  // px_q[col][row], col 0 is the oldest column.
  // w_use_q freezes the bank a window launched with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc_q <= '0;
      v0_q <= 1'b0;
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 3; r++)
          px_q[c][r] <= '0;
      for (int i = 0; i < 9; i++)
        w_use_q[i] <= '0;
    end else begin
      fc_q <= fc_d;
      v0_q <= launch;
      if (pe.valid_in) begin
        px_q[0] <= px_q[1];
        px_q[1] <= px_q[2];
        px_q[2] <= '{pe.din_1, pe.din_2, pe.din_3};
      end
      if (launch)
        w_use_q <= w_act_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      vo_q    <= 1'b0;
      for (int i = 0; i < 9; i++)
        prod_q[i] <= '0;
      for (int r = 0; r < 3; r++)
        row_q[r] <= '0;
      acc_q   <= '0;
      acc_o_q <= '0;
      q_o_q   <= '0;
    end else begin
      v1_q <= v0_q;
      v2_q <= v1_q;
      v3_q <= v2_q;
      vo_q <= v3_q;
      if (v0_q)
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            prod_q[r*3+c] <= PW'(px_q[c][r])
                           * PW'(w_use_q[r*3+c]);
      if (v1_q)
        for (int r = 0; r < 3; r++)
          row_q[r] <= RW'(prod_q[r*3])
                    + RW'(prod_q[r*3+1])
                    + RW'(prod_q[r*3+2]);
      if (v2_q)
        acc_q <= ACC_W'(row_q[0])
               + ACC_W'(row_q[1])
               + ACC_W'(row_q[2]);
      if (v3_q) begin
        acc_o_q <= acc_q;
        q_o_q   <= q_d;
      end
    end
  end

  // One guard bit keeps the rounding add from wrapping.
  always_comb begin
    r_x = {acc_q[ACC_W-1], acc_q};
    if (pe.relu_en && acc_q[ACC_W-1])
      r_x = '0;
    rnd_x = '0;
    if (pe.shift != 5'd0)
      rnd_x = {{ACC_W{1'b0}}, 1'b1} << (pe.shift - 5'd1);
    sh_x = (r_x + rnd_x) >>> pe.shift;
    if (sh_x > QMAX)
      q_d = QMAX[OUT_W-1:0];
    else if (sh_x < QMIN)
      q_d = QMIN[OUT_W-1:0];
    else
      q_d = sh_x[OUT_W-1:0];
  end

  assign pe.w_ready   = rdy_q;
  assign pe.valid_out = vo_q;
  assign pe.dout_acc  = acc_o_q;
  assign pe.dout_q    = q_o_q;
endmodule

// File: doc/conv3x3_window_pe.md
Name: conv3x3_window_pe

Overview:
- Parametrised 3x3 convolution processing element; successor to the fixed INT8 three-row multiplier.
- Accepts one pixel column per cycle (three rows) and builds its own 3x3 sliding window.
- Weights are loaded through a double-buffered serial port. MAC runs in a 4-stage pipeline with ReLU, rounding right-shift and saturation.
- Sits between the line-buffer block and the output feature-map writer.

Parameters:
DW, 8, signed pixel width
WW, 8, signed weight width
ACC_W, 20, accumulator width; must be >= DW+WW+4
OUT_W, 8, quantised output width (signed)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
w_load  in  1  weight write strobe
w_data  in  WW  weight value, row-major order w11..w33
w_ready  out  1  a complete weight set has been committed at least once
valid_in  in  1  column valid
row_start  in  1  qualified by valid_in: this column is the first of a new row
din_1  in  DW  top-row pixel (signed)
din_2  in  DW  middle-row pixel (signed)
din_3  in  DW  bottom-row pixel (signed)
relu_en  in  1  apply ReLU before quantisation
shift  in  5  requantise right-shift amount, 0..ACC_W-1
valid_out  out  1  output valid, one-cycle pulse per window
dout_acc  out  ACC_W  raw 9-term sum (pre-ReLU)
dout_q  out  OUT_W  post-processed, saturated result

Behaviour:
- Reset:
  - all outputs 0; window registers, both weight banks, weight index and fill counter 0; w_ready 0.
  - Asserting reset mid-operation flushes the pipeline; no valid_out pulse follows deassertion until a new window fills.
- Weight load:
  - Each w_load cycle writes w_data into shadow[idx]; idx increments 0..8.
  - On the write with idx==8, at the same edge: shadow plus the current word are copied to the active bank, idx wraps to 0, w_ready is set to 1.
  - Windows entering stage 1 after that edge use the new bank. Windows already in flight keep their products.
  - Partial loads never disturb the active bank.
- Window:
  - On valid_in: col0<=col1, col1<=col2, col2<={din_1,din_2,din_3}.
  - Fill counter fc saturates at 3. With valid_in & row_start, fc<=1 instead of incrementing.
  - A window launches at the accepting edge k when the post-update fc==3.
  - valid_in low: no shift, no launch; the window holds.
- Pipeline, column accepted at edge k:
  - k+1: 9 signed products, each DW+WW bits.
  - k+2: three row sums.
  - k+3: 9-term sum, sign-extended to ACC_W.
  - k+4: post-processing; dout_acc and dout_q are registered and valid_out=1.
- Back-to-back valid_in gives one result per cycle. Bubbles propagate as valid_out=0. dout_acc and dout_q hold their last values when valid_out=0.
- Post-processing:
  - r = (relu_en && acc<0) ? 0 : acc.
  - If shift>0: r = (r + 2^(shift-1)) >>> shift (arithmetic, round-half-up).
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Simultaneous w_load commit and window launch at the same edge: the launching window uses the OLD bank; the new bank applies from the next launch.

Test Plan:
- Weights rows {1,2,3}; columns of all-equal pixels 1, 2, 3 on k, k+1, k+2; shift=0 -> valid_out at k+6, dout_acc=42, dout_q=42.
- Same stimulus, shift=2 -> dout_q=11 ((42+2)>>2). Then shift=3 -> dout_q=5.
- All weights -1, pixels 10, relu_en=0 -> dout_acc=-90, dout_q=-90. relu_en=1 -> dout_acc=-90, dout_q=0.
- Saturation:
  - pixels 127, weights 127, shift=0 -> dout_acc=145161, dout_q=127.
  - pixels -128, weights 127 -> dout_acc=-146304, dout_q=-128.
- Row restart and bubbles: 5 columns streamed, then row_start on column 6 -> no valid_out for columns 6 and 7, valid_out for column 8. A valid_in gap of 2 cycles -> output pulses shift by 2 cycles, values unchanged.
- Weight reload: new set (all 2) streamed while windows run; commit coincides with a launch -> that window uses old weights, the next uses new ones.
  - Reset mid-pipeline -> all outputs 0, w_ready 0, no spurious valid_out.
